// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the external memory port arbiter.
//   state_t     : arbiter FSM states (IDLE -> CMD -> DATA -> IDLE)
//   REQ_*       : conventional requester slot numbers
//   idx_width() : index width for an N-entry vector (at least 1 bit)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int unsigned REQ_DCACHE = 0;
    localparam int unsigned REQ_ICACHE = 1;
    localparam int unsigned REQ_GP     = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational N-way round-robin picker.
// Searches i_req starting at index i_start, wrapping from N-1 to 0, and
// returns the first set position.
//   i_req    : candidate request vector
//   i_start  : index to begin the search at (must be < N)
//   o_onehot : one-hot winner, zero when no request
//   o_idx    : winner index (0 when no request)
//   o_valid  : at least one request was present
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [2*N-1:0] w_rot;
    logic [IW:0]    w_sum;

    always_comb begin
        // Rotate the doubled vector so bit 0 is the search start; the first
        // set bit at offset k is then requester (start + k) mod N.
        w_rot   = {i_req, i_req} >> i_start;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = {1'b0, i_start} + (IW+1)'(k);
            end
        end
        if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
        end
        o_idx    = w_sum[IW-1:0];
        o_onehot = o_valid ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory command port among N requesters
// (dcache, icache, graphics fetch). Round-robin arbitration with an urgent
// override; the port stays locked to the winner until its burst completes.
// Command fields are muxed, beat strobes routed; data does not pass here.
//   clk, rst       : clock, synchronous active-high reset
//   req            : per-requester request, held until its ack pulse
//   req_urgent     : urgent qualifier, sampled with req
//   req_addr       : packed addresses, slice i = requester i
//   req_rnw        : 1=read, 0=write
//   req_len        : packed burst lengths minus one
//   ack            : one-cycle pulse when the owner's command is accepted
//   gnt            : one-hot owner, held from CMD through the last beat
//   beat           : mem_beat routed to the owner
//   done           : pulse on the owner's last beat
//   mem_cmd_*      : command channel to the memory controller
//   mem_beat       : one data beat completed by the controller
//   busy           : arbiter not idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned LW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_urgent,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N-1:0]    req_rnw,
    input  logic [N*LW-1:0] req_len,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    beat,
    output logic [N-1:0]    done,
    output logic            mem_cmd_valid,
    input  logic            mem_cmd_ready,
    output logic [AW-1:0]   mem_cmd_addr,
    output logic            mem_cmd_rnw,
    output logic [LW-1:0]   mem_cmd_len,
    input  logic            mem_beat,
    output logic            busy
);

    localparam int unsigned IW = idx_width(N);

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_gnt;
    logic [IW-1:0]  r_rr_ptr;
    logic [AW-1:0]  r_addr;
    logic           r_rnw;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_cnt;

    logic [N-1:0]   w_urg;
    logic [N-1:0]   w_pick_req;
    logic [N-1:0]   w_win_oh;
    logic [IW-1:0]  w_win_idx;
    logic           w_win_valid;
    logic [AW-1:0]  w_win_addr;
    logic           w_win_rnw;
    logic [LW-1:0]  w_win_len;
    logic           w_last_beat;

    // Urgent requesters, if any, compete only among themselves.
    assign w_urg      = req & req_urgent;
    assign w_pick_req = (|w_urg) ? w_urg : req;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_start  (r_rr_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    always_comb begin
        w_win_addr = '0;
        w_win_rnw  = 1'b0;
        w_win_len  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_win_oh[i]) begin
                w_win_addr = req_addr[i*AW +: AW];
                w_win_rnw  = req_rnw[i];
                w_win_len  = req_len[i*LW +: LW];
            end
        end
    end

    assign w_last_beat = (r_state == ST_DATA) && mem_beat && (r_cnt == '0);

    always_comb begin
        w_next        = r_state;
        ack           = '0;
        beat          = '0;
        done          = '0;
        mem_cmd_valid = 1'b0;
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_next = ST_CMD;
                end
            end
            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    ack    = r_gnt;
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_beat) begin
                    beat = r_gnt;
                end
                if (w_last_beat) begin
                    done   = r_gnt;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_addr   <= '0;
            r_rnw    <= 1'b0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_gnt    <= w_win_oh;
                        r_addr   <= w_win_addr;
                        r_rnw    <= w_win_rnw;
                        r_len    <= w_win_len;
                        r_rr_ptr <= (w_win_idx == IW'(N-1)) ? '0 : w_win_idx + IW'(1);
                    end
                end
                ST_CMD: begin
                    if (mem_cmd_ready) begin
                        r_cnt <= r_len;
                    end
                end
                ST_DATA: begin
                    if (mem_beat) begin
                        if (r_cnt == '0) begin
                            r_gnt <= '0;
                        end else begin
                            r_cnt <= r_cnt - LW'(1);
                        end
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign mem_cmd_addr = r_addr;
    assign mem_cmd_rnw  = r_rnw;
    assign mem_cmd_len  = r_len;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, each cycle compared against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_urgent, req_rnw;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    ack, gnt, beat, done;
    logic            mem_cmd_valid, mem_cmd_ready, mem_cmd_rnw, mem_beat, busy;
    logic [AW-1:0]   mem_cmd_addr;
    logic [LW-1:0]   mem_cmd_len;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .AW(AW), .LW(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_urgent    (req_urgent),
        .req_addr      (req_addr),
        .req_rnw       (req_rnw),
        .req_len       (req_len),
        .ack           (ack),
        .gnt           (gnt),
        .beat          (beat),
        .done          (done),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_rnw   (mem_cmd_rnw),
        .mem_cmd_len   (mem_cmd_len),
        .mem_beat      (mem_beat),
        .busy          (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester side: pending commands per requester.
    bit            act   [N];
    logic [AW-1:0] a_addr[N];
    bit            a_rnw [N];
    logic [LW-1:0] a_len [N];
    bit            a_urg [N];
    bit            refill = 1'b0;

    // Reference model: owner of the port (-1 = none), whether its command is
    // still waiting for acceptance, beats still owed, and the search pointer.
    int            m_owner = -1;
    bit            m_incmd = 1'b0;
    int            m_left  = 0;
    int            m_ptr   = 0;
    logic [AW-1:0] m_addr  = '0;
    bit            m_rnw   = 1'b0;
    logic [LW-1:0] m_len   = '0;

    int gq[$];
    int obs_ack, obs_beat, obs_done;

    function automatic int pick(input bit [N-1:0] r, input bit [N-1:0] u, input int ptr);
        bit [N-1:0] cand;
        cand = ((r & u) != '0) ? (r & u) : r;
        for (int k = 0; k < N; k++) begin
            if (cand[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit r, input bit rdy, input bit mb);
        logic [N-1:0] e_gnt, e_ack, e_beat, e_done;
        bit   [N-1:0] rv, uv;
        int           w;
        @(negedge clk);
        rst           = r;
        mem_cmd_ready = rdy;
        mem_beat      = mb;
        for (int i = 0; i < N; i++) begin
            req[i] = act[i];
            if (act[i] && m_owner != i) begin
                req_urgent[i]          = a_urg[i];
                req_addr[i*AW +: AW]   = a_addr[i];
                req_rnw[i]             = a_rnw[i];
                req_len[i*LW +: LW]    = a_len[i];
            end else begin
                // Idle requesters and the locked owner present junk fields.
                req_urgent[i]          = 1'($urandom);
                req_addr[i*AW +: AW]   = $urandom;
                req_rnw[i]             = 1'($urandom);
                req_len[i*LW +: LW]    = LW'($urandom);
            end
        end
        #1;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_ack  = (m_owner >= 0 && m_incmd && rdy) ? e_gnt : '0;
        e_beat = (m_owner >= 0 && !m_incmd && mb) ? e_gnt : '0;
        e_done = (e_beat != '0 && m_left == 1) ? e_gnt : '0;
        check("gnt",   gnt,           e_gnt);
        check("ack",   ack,           e_ack);
        check("beat",  beat,          e_beat);
        check("done",  done,          e_done);
        check("valid", mem_cmd_valid, (m_owner >= 0 && m_incmd));
        check("busy",  busy,          (m_owner >= 0));
        check("addr",  mem_cmd_addr,  m_addr);
        check("rnw",   mem_cmd_rnw,   m_rnw);
        check("len",   mem_cmd_len,   m_len);
        if (ack  != '0) obs_ack++;
        if (beat != '0) obs_beat++;
        if (done != '0) obs_done++;

        if (r) begin
            m_owner = -1; m_incmd = 1'b0; m_left = 0; m_ptr = 0;
            m_addr = '0; m_rnw = 1'b0; m_len = '0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = req[i];
                uv[i] = req_urgent[i];
            end
            w = pick(rv, uv, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_incmd = 1'b1;
                m_addr = a_addr[w]; m_rnw = a_rnw[w]; m_len = a_len[w];
                m_ptr = (w + 1) % N;
            end
        end else if (m_incmd) begin
            if (rdy) begin
                m_incmd = 1'b0;
                m_left  = int'(m_len) + 1;
                gq.push_back(m_owner);
            end
        end else if (mb) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
        end

        for (int i = 0; i < N; i++) begin
            if (e_ack[i] && !refill) act[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] ad, input bit rw, input int ln, input bit ug);
        act[i] = 1'b1; a_addr[i] = ad; a_rnw[i] = rw; a_len[i] = LW'(ln); a_urg[i] = ug;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        gq.delete();
        obs_ack = 0; obs_beat = 0; obs_done = 0;
    endtask

    task automatic clear_obs();
        obs_ack = 0; obs_beat = 0; obs_done = 0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_urgent = '0; req_rnw = '0;
        req_addr = '0; req_len = '0; mem_cmd_ready = 1'b0; mem_beat = 1'b0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; a_addr[i] = '0; a_rnw[i] = 1'b0; a_len[i] = '0; a_urg[i] = 1'b0;
        end
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);

        // Single read burst, len=3
        set_req(REQ_DCACHE, 32'h1000_0040, 1'b1, 3, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        clear_obs();
        cycle(1'b0, 1'b1, 1'b0);
        check("single_ack_cycle1", 64'(obs_ack), 64'd1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("single_beats", 64'(obs_beat), 64'd4);
        check("single_done",  64'(obs_done), 64'd1);
        check("single_busy_after", 64'(busy), 64'd0);

        // Fairness with all three continuously requesting
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, $urandom, 1'($urandom), 0, 1'b0);
        for (int k = 0; k < 18; k++) cycle(1'b0, 1'b1, 1'b1);
        refill = 1'b0;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
        check("fair_ack_eq_done", 64'(obs_ack), 64'(obs_done));
        for (int k = 0; k < 6; k++)
            check($sformatf("fair_order%0d", k), 64'((gq.size() > k) ? gq[k] : -1), 64'(k % N));

        // Urgent graphics fetch pre-empts pending cpu requests
        do_reset();
        set_req(REQ_DCACHE, $urandom, 1'b1, 0, 1'b0);
        set_req(REQ_ICACHE, $urandom, 1'b1, 0, 1'b0);
        set_req(REQ_GP,     $urandom, 1'b1, 0, 1'b1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b1);
        check("urg_first",  64'((gq.size() > 0) ? gq[0] : -1), 64'(REQ_GP));
        check("urg_second", 64'((gq.size() > 1) ? gq[1] : -1), 64'(REQ_DCACHE));
        check("urg_third",  64'((gq.size() > 2) ? gq[2] : -1), 64'(REQ_ICACHE));

        // Backpressure with stray beats while the command waits
        do_reset();
        set_req(REQ_ICACHE, 32'hCAFE_0100, 1'b0, 2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        clear_obs();
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1);
        check("bp_no_ack",  64'(obs_ack),  64'd0);
        check("bp_no_beat", 64'(obs_beat), 64'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("bp_ack", 64'(obs_ack), 64'd1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
        check("bp_done", 64'(obs_done), 64'd1);

        // Reset in the middle of an 8-beat burst
        do_reset();
        set_req(REQ_DCACHE, $urandom, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        gq.delete();
        set_req(REQ_DCACHE, $urandom, 1'b0, 1, 1'b0);
        set_req(REQ_ICACHE, $urandom, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("rst_gnt_clear",  64'(gnt),  64'd0);
        check("rst_busy_clear", 64'(busy), 64'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("rst_first_winner", 64'((gq.size() > 0) ? gq[0] : -1), 64'(REQ_DCACHE));
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b1);

        // Maximum length burst
        do_reset();
        set_req(REQ_GP, $urandom, 1'b1, 7, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 1'b1);
        check("max_beats", 64'(obs_beat), 64'd8);
        check("max_done",  64'(obs_done), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] && ($urandom % 4) == 0)
                    set_req(i, $urandom, 1'($urandom), int'($urandom % 8), ($urandom % 4) == 0);
            end
            cycle(($urandom % 300) == 0, ($urandom % 3) != 0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
